// File: rtl/vga_pkg.sv
// Shared constants and helpers for the VGA image path.
package vga_pkg;

    // Visible timing of the display mode driven by vga_controller.
    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;

    // Scroll direction encodings as presented on the dir input.
    localparam logic [1:0] DIR_LEFT  = 2'd0;
    localparam logic [1:0] DIR_RIGHT = 2'd1;
    localparam logic [1:0] DIR_UP    = 2'd2;
    localparam logic [1:0] DIR_DOWN  = 2'd3;

    // Number of bits needed to hold values 0 .. value-1 (minimum 1).
    function automatic int clog2(input int value);
        int bits;
        bits = 1;
        for (int i = 1; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                bits = i + 1;
            end
        end
        return bits;
    endfunction

endpackage

// File: rtl/scroll_offset_ctrl.sv
// Frame-tick detection and per-frame scroll offset counters with wrap.
module scroll_offset_ctrl
    import vga_pkg::*;
#(
    parameter int V_LINES = 480,
    parameter int IMG_W   = 320,
    parameter int IMG_H   = 240,
    parameter int SPEED_W = 4,
    parameter int X_W     = 9,
    parameter int Y_W     = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [9:0]         h_cnt,
    input  logic [9:0]         v_cnt,
    input  logic               scroll_en,
    input  logic [1:0]         dir,
    input  logic [SPEED_W-1:0] speed,
    output logic               frame_tick,
    output logic [X_W-1:0]     off_x,
    output logic [Y_W-1:0]     off_y
);

    logic               vblank_hit_s;
    logic               vblank_cmp_r;
    logic               frame_tick_r;
    logic [SPEED_W-1:0] frame_cnt_r;
    logic [X_W-1:0]     off_x_r;
    logic [Y_W-1:0]     off_y_r;
    logic [X_W-1:0]     next_x_s;
    logic [Y_W-1:0]     next_y_s;

    assign vblank_hit_s = (v_cnt == 10'(V_LINES)) && (h_cnt == 10'd0);

    // Next offsets for one scroll step, wrapping by compare-and-select.
    always_comb begin
        next_x_s = off_x_r;
        next_y_s = off_y_r;
        case (dir)
            DIR_LEFT: begin
                if (off_x_r == X_W'(IMG_W - 1)) next_x_s = {X_W{1'b0}};
                else                            next_x_s = off_x_r + X_W'(1);
            end
            DIR_RIGHT: begin
                if (off_x_r == {X_W{1'b0}}) next_x_s = X_W'(IMG_W - 1);
                else                        next_x_s = off_x_r - X_W'(1);
            end
            DIR_UP: begin
                if (off_y_r == Y_W'(IMG_H - 1)) next_y_s = {Y_W{1'b0}};
                else                            next_y_s = off_y_r + Y_W'(1);
            end
            DIR_DOWN: begin
                if (off_y_r == {Y_W{1'b0}}) next_y_s = Y_W'(IMG_H - 1);
                else                        next_y_s = off_y_r - Y_W'(1);
            end
            default: begin
                next_x_s = off_x_r;
                next_y_s = off_y_r;
            end
        endcase
    end

    // Edge-detect the vblank start and advance offsets once per tick.
    always_ff @(posedge clk) begin
        if (!rst) begin
            vblank_cmp_r <= 1'b0;
            frame_tick_r <= 1'b0;
            frame_cnt_r  <= {SPEED_W{1'b0}};
            off_x_r      <= {X_W{1'b0}};
            off_y_r      <= {Y_W{1'b0}};
        end else begin
            vblank_cmp_r <= vblank_hit_s;
            frame_tick_r <= vblank_hit_s & ~vblank_cmp_r;
            if (frame_tick_r && scroll_en) begin
                if (frame_cnt_r == speed) begin
                    frame_cnt_r <= {SPEED_W{1'b0}};
                    off_x_r     <= next_x_s;
                    off_y_r     <= next_y_s;
                end else begin
                    // Wraps through 2^SPEED_W if speed was lowered below the count.
                    frame_cnt_r <= frame_cnt_r + SPEED_W'(1);
                end
            end
        end
    end

    assign frame_tick = frame_tick_r;
    assign off_x      = off_x_r;
    assign off_y      = off_y_r;

endmodule

// File: rtl/vga_scroll_addr_gen.sv
// Screen-to-image address generator with scaled, wrap-around scrolling.
// Two-cycle pipeline: wrapped image coordinates, then linear RAM address.
module vga_scroll_addr_gen #(
    parameter int H_ACTIVE    = vga_pkg::H_ACTIVE,
    parameter int V_ACTIVE    = vga_pkg::V_ACTIVE,
    parameter int IMG_W       = 320,
    parameter int IMG_H       = 240,
    parameter int SCALE_SHIFT = 1,
    parameter int ADDR_W      = 17,
    parameter int SPEED_W     = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [9:0]         h_cnt,
    input  logic [9:0]         v_cnt,
    input  logic               valid,
    input  logic               scroll_en,
    input  logic [1:0]         dir,
    input  logic [SPEED_W-1:0] speed,
    output logic [ADDR_W-1:0]  pixel_addr,
    output logic               addr_valid,
    output logic               frame_tick
);
    import vga_pkg::*;

    localparam int X_W = clog2(IMG_W);
    localparam int Y_W = clog2(IMG_H);
    // Coordinate sums need headroom for scaled screen position plus offset.
    localparam int CX_W = clog2(H_ACTIVE + IMG_W) + 1;
    localparam int CY_W = clog2(V_ACTIVE + IMG_H) + 1;

    logic [X_W-1:0]    off_x_s;
    logic [Y_W-1:0]    off_y_s;
    logic [CX_W-1:0]   sum_x_s;
    logic [CY_W-1:0]   sum_y_s;
    logic [CX_W-1:0]   ix_s;
    logic [CY_W-1:0]   iy_s;
    logic [CX_W-1:0]   ix_r;
    logic [CY_W-1:0]   iy_r;
    logic              valid_d1_r;
    logic [ADDR_W-1:0] addr_s;
    logic [ADDR_W-1:0] pixel_addr_r;
    logic              addr_valid_r;

    scroll_offset_ctrl #(
        .V_LINES (V_ACTIVE),
        .IMG_W   (IMG_W),
        .IMG_H   (IMG_H),
        .SPEED_W (SPEED_W),
        .X_W     (X_W),
        .Y_W     (Y_W)
    ) u_offset_ctrl (
        .clk        (clk),
        .rst        (rst),
        .h_cnt      (h_cnt),
        .v_cnt      (v_cnt),
        .scroll_en  (scroll_en),
        .dir        (dir),
        .speed      (speed),
        .frame_tick (frame_tick),
        .off_x      (off_x_s),
        .off_y      (off_y_s)
    );

    // Scaled coordinate plus offset, folded back once into the image.
    always_comb begin
        sum_x_s = CX_W'(h_cnt >> SCALE_SHIFT) + CX_W'(off_x_s);
        sum_y_s = CY_W'(v_cnt >> SCALE_SHIFT) + CY_W'(off_y_s);
        if (sum_x_s >= CX_W'(IMG_W)) ix_s = sum_x_s - CX_W'(IMG_W);
        else                         ix_s = sum_x_s;
        if (sum_y_s >= CY_W'(IMG_H)) iy_s = sum_y_s - CY_W'(IMG_H);
        else                         iy_s = sum_y_s;
    end

    assign addr_s = ADDR_W'(iy_r) * ADDR_W'(IMG_W) + ADDR_W'(ix_r);

    // Pipeline registers: stage 1 holds coordinates, stage 2 the address.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ix_r         <= {CX_W{1'b0}};
            iy_r         <= {CY_W{1'b0}};
            valid_d1_r   <= 1'b0;
            pixel_addr_r <= {ADDR_W{1'b0}};
            addr_valid_r <= 1'b0;
        end else begin
            ix_r         <= ix_s;
            iy_r         <= iy_s;
            valid_d1_r   <= valid;
            pixel_addr_r <= addr_s;
            addr_valid_r <= valid_d1_r;
        end
    end

    assign pixel_addr = pixel_addr_r;
    assign addr_valid = addr_valid_r;

endmodule

// File: tb/tb_vga_scroll_addr_gen.sv
// Directed bench for vga_scroll_addr_gen with hand-computed addresses.
module tb_vga_scroll_addr_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  h_cnt;
    logic [9:0]  v_cnt;
    logic        valid;
    logic        scroll_en;
    logic [1:0]  dir;
    logic [3:0]  speed;
    logic [16:0] pixel_addr;
    logic        addr_valid;
    logic        frame_tick;

    int tests_run    = 0;
    int tests_failed = 0;

    vga_scroll_addr_gen dut (
        .clk        (clk),
        .rst        (rst),
        .h_cnt      (h_cnt),
        .v_cnt      (v_cnt),
        .valid      (valid),
        .scroll_en  (scroll_en),
        .dir        (dir),
        .speed      (speed),
        .pixel_addr (pixel_addr),
        .addr_valid (addr_valid),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    // Present a coordinate and wait for it to reach the output stage.
    task automatic probe(input logic [9:0] h, input logic [9:0] v, input logic vld);
        @(posedge clk); #1;
        h_cnt = h; v_cnt = v; valid = vld;
        @(posedge clk);
        @(posedge clk); #1;
    endtask

    // One vblank: start condition held 3 cycles; counts frame_tick pulses.
    task automatic run_frame(output int ticks);
        ticks = 0;
        @(posedge clk); #1;
        v_cnt = 10'd480; h_cnt = 10'd0; valid = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            if (frame_tick) ticks++;
        end
        v_cnt = 10'd481; h_cnt = 10'd1;
        repeat (2) begin
            @(posedge clk); #1;
            if (frame_tick) ticks++;
        end
        v_cnt = 10'd0; h_cnt = 10'd0;
    endtask

    task automatic reset_dut();
        @(posedge clk); #1;
        rst = 1'b0; valid = 1'b0; h_cnt = 10'd0; v_cnt = 10'd0;
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0; scroll_en = 1'b0; dir = 2'd0; speed = 4'd0;
        h_cnt = 10'd0; v_cnt = 10'd480; valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if (pixel_addr !== 17'd0) begin
            tests_failed++; $display("FAIL reset_addr got %0d want 0", pixel_addr);
        end
        tests_run++;
        if (addr_valid !== 1'b0) begin
            tests_failed++; $display("FAIL reset_valid got %b want 0", addr_valid);
        end
        tests_run++;
        if (frame_tick !== 1'b0) begin
            tests_failed++; $display("FAIL reset_tick got %b want 0", frame_tick);
        end
    endtask

    task automatic test_static();
        int ticks;
        h_cnt = 10'd5; v_cnt = 10'd3; valid = 1'b1; rst = 1'b1;
        @(posedge clk);
        @(posedge clk); #1;
        tests_run++;
        if (pixel_addr !== 17'd322) begin
            tests_failed++; $display("FAIL static_addr got %0d want 322", pixel_addr);
        end
        tests_run++;
        if (addr_valid !== 1'b1) begin
            tests_failed++; $display("FAIL static_valid got %b want 1", addr_valid);
        end
        run_frame(ticks);
        tests_run++;
        if (ticks !== 1) begin
            tests_failed++; $display("FAIL static_tick got %0d want 1", ticks);
        end
        probe(10'd0, 10'd0, 1'b1);
        tests_run++;
        if (pixel_addr !== 17'd0) begin
            tests_failed++; $display("FAIL frozen_addr got %0d want 0", pixel_addr);
        end
        probe(10'd700, 10'd500, 1'b0);
        tests_run++;
        if (pixel_addr !== 17'd3230) begin
            tests_failed++; $display("FAIL offscreen_addr got %0d want 3230", pixel_addr);
        end
        tests_run++;
        if (addr_valid !== 1'b0) begin
            tests_failed++; $display("FAIL offscreen_valid got %b want 0", addr_valid);
        end
    endtask

    task automatic test_left();
        int ticks;
        reset_dut();
        scroll_en = 1'b1; dir = 2'd0; speed = 4'd0;
        for (int f = 0; f < 3; f++) begin
            run_frame(ticks);
            tests_run++;
            if (ticks !== 1) begin
                tests_failed++; $display("FAIL left_tick frame %0d got %0d want 1", f, ticks);
            end
        end
        probe(10'd0, 10'd0, 1'b1);
        tests_run++;
        if (pixel_addr !== 17'd3) begin
            tests_failed++; $display("FAIL left_addr got %0d want 3", pixel_addr);
        end
        probe(10'd638, 10'd0, 1'b1);
        tests_run++;
        if (pixel_addr !== 17'd2) begin
            tests_failed++; $display("FAIL left_wrap got %0d want 2", pixel_addr);
        end
    endtask

    task automatic test_right();
        int ticks;
        reset_dut();
        scroll_en = 1'b1; dir = 2'd1; speed = 4'd0;
        run_frame(ticks);
        probe(10'd0, 10'd0, 1'b1);
        tests_run++;
        if (pixel_addr !== 17'd319) begin
            tests_failed++; $display("FAIL right_addr got %0d want 319", pixel_addr);
        end
        probe(10'd2, 10'd0, 1'b1);
        tests_run++;
        if (pixel_addr !== 17'd0) begin
            tests_failed++; $display("FAIL right_wrap got %0d want 0", pixel_addr);
        end
    endtask

    task automatic test_down();
        int ticks;
        reset_dut();
        scroll_en = 1'b1; dir = 2'd3; speed = 4'd2;
        repeat (6) run_frame(ticks);
        probe(10'd0, 10'd4, 1'b1);
        tests_run++;
        if (pixel_addr !== 17'd0) begin
            tests_failed++; $display("FAIL down_wrap got %0d want 0", pixel_addr);
        end
        probe(10'd0, 10'd0, 1'b1);
        tests_run++;
        if (pixel_addr !== 17'd76160) begin
            tests_failed++; $display("FAIL down_addr got %0d want 76160", pixel_addr);
        end
        probe(10'd0, 10'd2, 1'b1);
        tests_run++;
        if (pixel_addr !== 17'd76480) begin
            tests_failed++; $display("FAIL down_last got %0d want 76480", pixel_addr);
        end
    endtask

    task automatic test_mid_change();
        int ticks;
        reset_dut();
        scroll_en = 1'b1; dir = 2'd2; speed = 4'd0;
        run_frame(ticks);
        probe(10'd0, 10'd0, 1'b1);
        tests_run++;
        if (pixel_addr !== 17'd320) begin
            tests_failed++; $display("FAIL up_addr got %0d want 320", pixel_addr);
        end
        dir = 2'd0;
        probe(10'd0, 10'd200, 1'b1);
        tests_run++;
        if (pixel_addr !== 17'd32320) begin
            tests_failed++; $display("FAIL midframe_hold got %0d want 32320", pixel_addr);
        end
        run_frame(ticks);
        probe(10'd0, 10'd0, 1'b1);
        tests_run++;
        if (pixel_addr !== 17'd321) begin
            tests_failed++; $display("FAIL dir_change got %0d want 321", pixel_addr);
        end
    endtask

    task automatic test_speed_wrap();
        int ticks;
        reset_dut();
        scroll_en = 1'b1; dir = 2'd0; speed = 4'd3;
        repeat (2) run_frame(ticks);
        speed = 4'd0;
        repeat (14) run_frame(ticks);
        probe(10'd0, 10'd0, 1'b1);
        tests_run++;
        if (pixel_addr !== 17'd0) begin
            tests_failed++; $display("FAIL speed_wrap_hold got %0d want 0", pixel_addr);
        end
        run_frame(ticks);
        probe(10'd0, 10'd0, 1'b1);
        tests_run++;
        if (pixel_addr !== 17'd1) begin
            tests_failed++; $display("FAIL speed_wrap_step got %0d want 1", pixel_addr);
        end
    endtask

    task automatic test_reset_mid();
        int ticks;
        reset_dut();
        scroll_en = 1'b1; dir = 2'd0; speed = 4'd0;
        repeat (2) run_frame(ticks);
        probe(10'd0, 10'd0, 1'b1);
        tests_run++;
        if (pixel_addr !== 17'd2) begin
            tests_failed++; $display("FAIL premid_addr got %0d want 2", pixel_addr);
        end
        @(posedge clk); #1;
        v_cnt = 10'd200; h_cnt = 10'd10; valid = 1'b1; rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1; h_cnt = 10'd638; v_cnt = 10'd479; valid = 1'b1;
        @(posedge clk);
        @(posedge clk); #1;
        tests_run++;
        if (pixel_addr !== 17'd76799) begin
            tests_failed++; $display("FAIL midreset_addr got %0d want 76799", pixel_addr);
        end
        tests_run++;
        if (addr_valid !== 1'b1) begin
            tests_failed++; $display("FAIL midreset_valid got %b want 1", addr_valid);
        end
        probe(10'd0, 10'd0, 1'b1);
        tests_run++;
        if (pixel_addr !== 17'd0) begin
            tests_failed++; $display("FAIL midreset_origin got %0d want 0", pixel_addr);
        end
    endtask

    initial begin
        test_reset();
        test_static();
        test_left();
        test_right();
        test_down();
        test_mid_change();
        test_speed_wrap();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
